// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: a serial scan of the voice table is followed by one commit per event.
// The shadow voice state is published to the oscillators on each pblrc rise.
module voice_allocator #(
  parameter int NUM_VOICES    = 4,
  parameter int VOLUME_BITS   = 3,
  parameter int FREQ_RES_BITS = 8,
  parameter int NOTE_BITS     = 7,
  parameter int AGE_BITS      = 8,
  parameter int STEAL_EN      = 1
) (
  input  logic                                mclk,
  input  logic                                rst_n,
  input  logic                                pblrc,
  input  logic                                ev_valid,
  output logic                                ev_ready,
  input  logic                                ev_on,
  input  logic [NOTE_BITS-1:0]                ev_note,
  input  logic [FREQ_RES_BITS-1:0]            ev_freq,
  input  logic [VOLUME_BITS-1:0]              ev_vol,
  output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
  output logic [NUM_VOICES*VOLUME_BITS-1:0]   voice_volume,
  output logic [NUM_VOICES-1:0]               voice_active,
  output logic                                steal_pulse,
  output logic                                drop_pulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0]    IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_BITS-1:0] AGE_MAX  = {AGE_BITS{1'b1}};
  localparam logic [AGE_BITS-1:0] AGE_ONE  = AGE_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                   state_r;
  logic [IDX_W-1:0]         scan_idx_r;
  logic                     pblrc_r;
  logic                     lat_on_r;
  logic [NOTE_BITS-1:0]     lat_note_r;
  logic [FREQ_RES_BITS-1:0] lat_freq_r;
  logic [VOLUME_BITS-1:0]   lat_vol_r;
  logic                     match_found_r, free_found_r, oldest_found_r;
  logic [IDX_W-1:0]         match_idx_r, free_idx_r, oldest_idx_r;
  logic [AGE_BITS-1:0]      oldest_age_r;

  logic                     act_r  [NUM_VOICES];
  logic [NOTE_BITS-1:0]     note_r [NUM_VOICES];
  logic [FREQ_RES_BITS-1:0] freq_r [NUM_VOICES];
  logic [VOLUME_BITS-1:0]   vol_r  [NUM_VOICES];
  logic [AGE_BITS-1:0]      age_r  [NUM_VOICES];

  logic                     is_on_s, tgt_valid_s, do_steal_s, do_drop_s;
  logic [IDX_W-1:0]         tgt_idx_s;

  // Commit decision from the scan results: retrigger, lowest free, steal oldest, or drop.
  always_comb begin
    is_on_s     = lat_on_r && (lat_vol_r != {VOLUME_BITS{1'b0}});
    tgt_valid_s = 1'b0;
    tgt_idx_s   = {IDX_W{1'b0}};
    do_steal_s  = 1'b0;
    do_drop_s   = 1'b0;
    if (match_found_r) begin
      tgt_valid_s = 1'b1;
      tgt_idx_s   = match_idx_r;
    end else if (is_on_s && free_found_r) begin
      tgt_valid_s = 1'b1;
      tgt_idx_s   = free_idx_r;
    end else if (is_on_s && (STEAL_EN != 0)) begin
      tgt_valid_s = 1'b1;
      tgt_idx_s   = oldest_idx_r;
      do_steal_s  = 1'b1;
    end else begin
      do_drop_s   = 1'b1;
    end
  end

  // Event FSM, voice shadow table, frame-synchronous publish and strobes.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      scan_idx_r     <= {IDX_W{1'b0}};
      ev_ready       <= 1'b0;
      pblrc_r        <= 1'b0;
      lat_on_r       <= 1'b0;
      lat_note_r     <= {NOTE_BITS{1'b0}};
      lat_freq_r     <= {FREQ_RES_BITS{1'b0}};
      lat_vol_r      <= {VOLUME_BITS{1'b0}};
      match_found_r  <= 1'b0;
      free_found_r   <= 1'b0;
      oldest_found_r <= 1'b0;
      match_idx_r    <= {IDX_W{1'b0}};
      free_idx_r     <= {IDX_W{1'b0}};
      oldest_idx_r   <= {IDX_W{1'b0}};
      oldest_age_r   <= {AGE_BITS{1'b0}};
      steal_pulse    <= 1'b0;
      drop_pulse     <= 1'b0;
      voice_freq     <= {(NUM_VOICES*FREQ_RES_BITS){1'b0}};
      voice_volume   <= {(NUM_VOICES*VOLUME_BITS){1'b0}};
      voice_active   <= {NUM_VOICES{1'b0}};
      for (int i = 0; i < NUM_VOICES; i++) begin
        act_r[i]  <= 1'b0;
        note_r[i] <= {NOTE_BITS{1'b0}};
        freq_r[i] <= {FREQ_RES_BITS{1'b0}};
        vol_r[i]  <= {VOLUME_BITS{1'b0}};
        age_r[i]  <= {AGE_BITS{1'b0}};
      end
    end else begin
      pblrc_r     <= pblrc;
      steal_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
      // Publishing reads the pre-commit shadow, so a coincident commit waits a frame.
      if (pblrc && !pblrc_r) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          voice_freq[i*FREQ_RES_BITS +: FREQ_RES_BITS] <= freq_r[i];
          voice_volume[i*VOLUME_BITS +: VOLUME_BITS]   <= vol_r[i];
          voice_active[i]                              <= act_r[i];
        end
      end
      case (state_r)
        ST_IDLE: begin
          if (ev_valid && ev_ready) begin
            ev_ready       <= 1'b0;
            lat_on_r       <= ev_on;
            lat_note_r     <= ev_note;
            lat_freq_r     <= ev_freq;
            lat_vol_r      <= ev_vol;
            match_found_r  <= 1'b0;
            free_found_r   <= 1'b0;
            oldest_found_r <= 1'b0;
            scan_idx_r     <= {IDX_W{1'b0}};
            state_r        <= ST_SCAN;
          end else begin
            ev_ready <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (act_r[scan_idx_r] && (note_r[scan_idx_r] == lat_note_r) && !match_found_r) begin
            match_found_r <= 1'b1;
            match_idx_r   <= scan_idx_r;
          end
          if (!act_r[scan_idx_r] && !free_found_r) begin
            free_found_r <= 1'b1;
            free_idx_r   <= scan_idx_r;
          end
          if (act_r[scan_idx_r] && (!oldest_found_r || (age_r[scan_idx_r] > oldest_age_r))) begin
            oldest_found_r <= 1'b1;
            oldest_idx_r   <= scan_idx_r;
            oldest_age_r   <= age_r[scan_idx_r];
          end
          if (scan_idx_r == IDX_LAST) begin
            state_r <= ST_COMMIT;
          end else begin
            scan_idx_r <= scan_idx_r + IDX_ONE;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (tgt_valid_s && (tgt_idx_s == IDX_W'(i))) begin
              if (is_on_s) begin
                act_r[i]  <= 1'b1;
                note_r[i] <= lat_note_r;
                freq_r[i] <= lat_freq_r;
                vol_r[i]  <= lat_vol_r;
                age_r[i]  <= {AGE_BITS{1'b0}};
              end else begin
                act_r[i]  <= 1'b0;
                vol_r[i]  <= {VOLUME_BITS{1'b0}};
              end
            end else if (is_on_s && tgt_valid_s && act_r[i] && (age_r[i] != AGE_MAX)) begin
              age_r[i] <= age_r[i] + AGE_ONE;
            end
          end
          steal_pulse <= do_steal_s;
          drop_pulse  <= do_drop_s;
          ev_ready    <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          ev_ready <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench: one stealing and one dropping allocator share stimulus and are compared
// every cycle against a per-event behavioural model of the voice table.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int VB = 3;
  localparam int FB = 8;
  localparam int NB = 7;
  localparam int AB = 8;

  logic mclk, rst_n, pblrc, ev_valid, ev_on;
  logic [NB-1:0] ev_note;
  logic [FB-1:0] ev_freq;
  logic [VB-1:0] ev_vol;

  logic          rdy    [2];
  logic [NV*FB-1:0] vfreq [2];
  logic [NV*VB-1:0] vvol  [2];
  logic [NV-1:0]    vact  [2];
  logic          steal  [2];
  logic          drop   [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  voice_allocator #(.NUM_VOICES(NV), .VOLUME_BITS(VB), .FREQ_RES_BITS(FB), .NOTE_BITS(NB),
                    .AGE_BITS(AB), .STEAL_EN(1)) u_steal (
    .mclk(mclk), .rst_n(rst_n), .pblrc(pblrc), .ev_valid(ev_valid), .ev_ready(rdy[0]),
    .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq), .ev_vol(ev_vol),
    .voice_freq(vfreq[0]), .voice_volume(vvol[0]), .voice_active(vact[0]),
    .steal_pulse(steal[0]), .drop_pulse(drop[0]));

  voice_allocator #(.NUM_VOICES(NV), .VOLUME_BITS(VB), .FREQ_RES_BITS(FB), .NOTE_BITS(NB),
                    .AGE_BITS(AB), .STEAL_EN(0)) u_drop (
    .mclk(mclk), .rst_n(rst_n), .pblrc(pblrc), .ev_valid(ev_valid), .ev_ready(rdy[1]),
    .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq), .ev_vol(ev_vol),
    .voice_freq(vfreq[1]), .voice_volume(vvol[1]), .voice_active(vact[1]),
    .steal_pulse(steal[1]), .drop_pulse(drop[1]));

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Behavioural model: per-DUT voice table, published copy and handshake timing.
  bit          m_act  [2][NV];
  logic [NB-1:0] m_note [2][NV];
  logic [FB-1:0] m_freq [2][NV];
  logic [VB-1:0] m_vol  [2][NV];
  int          m_age  [2][NV];
  bit          p_act  [2][NV];
  logic [FB-1:0] p_freq [2][NV];
  logic [VB-1:0] p_vol  [2][NV];
  bit          m_ready [2];
  bit          m_busy  [2];
  int          m_cnt   [2];
  bit          m_steal [2];
  bit          m_drop  [2];
  bit          l_on    [2];
  logic [NB-1:0] l_note [2];
  logic [FB-1:0] l_freq [2];
  logic [VB-1:0] l_vol  [2];
  bit          m_prev;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NV; i++) begin
        m_act[d][i] = 0; m_note[d][i] = '0; m_freq[d][i] = '0; m_vol[d][i] = '0;
        m_age[d][i] = 0; p_act[d][i] = 0; p_freq[d][i] = '0; p_vol[d][i] = '0;
      end
      m_ready[d] = 0; m_busy[d] = 0; m_cnt[d] = 0; m_steal[d] = 0; m_drop[d] = 0;
    end
    m_prev = 0;
  endtask

  task automatic model_commit(input int d);
    bit on;
    int match, free, oldest, tgt;
    on = l_on[d] && (l_vol[d] != 3'd0);
    match = -1; free = -1; oldest = -1;
    for (int i = 0; i < NV; i++) begin
      if (m_act[d][i] && m_note[d][i] == l_note[d] && match < 0) match = i;
      if (!m_act[d][i] && free < 0) free = i;
      if (m_act[d][i] && (oldest < 0 || m_age[d][i] > m_age[d][oldest])) oldest = i;
    end
    if (on) begin
      if (match >= 0) tgt = match;
      else if (free >= 0) tgt = free;
      else if (d == 0) begin tgt = oldest; m_steal[d] = 1; end
      else tgt = -1;
      if (tgt < 0) m_drop[d] = 1;
      else begin
        for (int i = 0; i < NV; i++) begin
          if (i == tgt) begin
            m_act[d][i] = 1; m_note[d][i] = l_note[d]; m_freq[d][i] = l_freq[d];
            m_vol[d][i] = l_vol[d]; m_age[d][i] = 0;
          end else if (m_act[d][i]) begin
            m_age[d][i] = (m_age[d][i] < 255) ? m_age[d][i] + 1 : 255;
          end
        end
      end
    end else if (match >= 0) begin
      m_act[d][match] = 0; m_vol[d][match] = '0;
    end else begin
      m_drop[d] = 1;
    end
  endtask

  task automatic model_step();
    bit rise;
    if (!rst_n) begin
      model_reset();
    end else begin
      rise = pblrc && !m_prev;
      for (int d = 0; d < 2; d++) begin
        if (rise) begin
          for (int i = 0; i < NV; i++) begin
            p_act[d][i] = m_act[d][i]; p_freq[d][i] = m_freq[d][i]; p_vol[d][i] = m_vol[d][i];
          end
        end
        m_steal[d] = 0; m_drop[d] = 0;
        if (!m_busy[d]) begin
          if (m_ready[d] && ev_valid) begin
            l_on[d] = ev_on; l_note[d] = ev_note; l_freq[d] = ev_freq; l_vol[d] = ev_vol;
            m_busy[d] = 1; m_cnt[d] = NV + 1; m_ready[d] = 0;
          end else begin
            m_ready[d] = 1;
          end
        end else begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            model_commit(d);
            m_busy[d] = 0; m_ready[d] = 1;
          end
        end
      end
      m_prev = pblrc;
    end
  endtask

  function automatic logic [NV*FB-1:0] exp_freq(input int d);
    logic [NV*FB-1:0] r;
    for (int i = 0; i < NV; i++) r[i*FB +: FB] = p_freq[d][i];
    return r;
  endfunction

  function automatic logic [NV*VB-1:0] exp_vol(input int d);
    logic [NV*VB-1:0] r;
    for (int i = 0; i < NV; i++) r[i*VB +: VB] = p_vol[d][i];
    return r;
  endfunction

  function automatic logic [NV-1:0] exp_act(input int d);
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = p_act[d][i];
    return r;
  endfunction

  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, got, want, $time);
    end
  endtask

  // Cycle-by-cycle comparison of both DUTs against the model, away from the active edge.
  always @(negedge mclk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("ev_ready", d, 32'(rdy[d]), 32'(m_ready[d]));
        chk("steal_pulse", d, 32'(steal[d]), 32'(m_steal[d]));
        chk("drop_pulse", d, 32'(drop[d]), 32'(m_drop[d]));
        chk("voice_freq", d, 32'(vfreq[d]), 32'(exp_freq(d)));
        chk("voice_volume", d, 32'(vvol[d]), 32'(exp_vol(d)));
        chk("voice_active", d, 32'(vact[d]), 32'(exp_act(d)));
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1 model_step();
      #1;
    end
  endtask

  task automatic send(input bit on, input int note, input int freq, input int vol);
    int w;
    w = 0;
    while (rdy[0] !== 1'b1 && w < 50) begin cyc(1); w++; end
    if (w >= 50) chk("send_timeout", 0, 32'(rdy[0]), 32'd1);
    ev_on = on; ev_note = NB'(note); ev_freq = FB'(freq); ev_vol = VB'(vol);
    ev_valid = 1'b1;
    cyc(1);
    ev_valid = 1'b0;
  endtask

  task automatic publish();
    pblrc = 1'b0; cyc(1);
    pblrc = 1'b1; cyc(1);
    pblrc = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0; model_reset(); cyc(2);
    rst_n = 1'b1; cyc(1);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b1; pblrc = 1'b0; ev_valid = 1'b0; ev_on = 1'b0;
    ev_note = '0; ev_freq = '0; ev_vol = '0;
    #1 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    cyc(2);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", d, 32'(rdy[d]), 32'd0);
      chk("reset_active", d, 32'(vact[d]), 32'd0);
      chk("reset_freq", d, 32'(vfreq[d]), 32'd0);
    end
    rst_n = 1'b1;
    cyc(1);
    chk("ready_after_reset", 0, 32'(rdy[0]), 32'd1);

    // First note lands in voice 0 and appears only after a frame rise.
    send(1'b1, 60, 8'h40, 7);
    cnt = 0;
    while (rdy[0] == 1'b0 && cnt < 20) begin cyc(1); cnt++; end
    chk("ready_low_cycles", 0, 32'(cnt), 32'(NV + 1));
    chk("unpublished_active", 0, 32'(vact[0]), 32'd0);
    publish();
    for (int d = 0; d < 2; d++) begin
      chk("first_freq", d, 32'(vfreq[d]), 32'h0000_0040);
      chk("first_vol", d, 32'(vvol[d]), 32'h0000_0007);
      chk("first_active", d, 32'(vact[d]), 32'h1);
    end

    // Fill all voices, then a fifth note steals voice 0 or is dropped.
    send(1'b1, 62, 8'h41, 5);
    send(1'b1, 64, 8'h42, 4);
    send(1'b1, 65, 8'h43, 3);
    send(1'b1, 67, 8'h50, 6);
    cyc(NV + 1);
    chk("steal_on_full", 0, 32'(steal[0]), 32'd1);
    chk("no_drop_on_steal", 0, 32'(drop[0]), 32'd0);
    chk("drop_on_full", 1, 32'(drop[1]), 32'd1);
    chk("no_steal_when_off", 1, 32'(steal[1]), 32'd0);
    cyc(1);
    chk("steal_one_cycle", 0, 32'(steal[0]), 32'd0);
    publish();
    chk("stolen_freq", 0, 32'(vfreq[0]), 32'h4342_4150);
    chk("kept_freq", 1, 32'(vfreq[1]), 32'h4342_4140);
    chk("all_active", 0, 32'(vact[0]), 32'hF);

    // Retrigger, release and unmatched release.
    reset_all();
    send(1'b1, 60, 8'h40, 7);
    send(1'b1, 60, 8'h44, 3);
    cyc(NV + 2);
    publish();
    chk("retrig_active", 0, 32'(vact[0]), 32'h1);
    chk("retrig_vol", 0, 32'(vvol[0]), 32'h3);
    chk("retrig_freq", 0, 32'(vfreq[0]), 32'h44);
    send(1'b0, 60, 0, 0);
    cyc(NV + 2);
    publish();
    chk("release_active", 0, 32'(vact[0]), 32'h0);
    chk("release_freq_held", 0, 32'(vfreq[0]), 32'h44);
    send(1'b0, 61, 0, 0);
    cyc(NV + 1);
    chk("unmatched_off_drop", 0, 32'(drop[0]), 32'd1);

    // Commit on the same edge as a frame rise publishes the old shadow.
    send(1'b1, 70, 8'h22, 6);
    cyc(NV);
    pblrc = 1'b1;
    cyc(1);
    chk("coincident_old_active", 0, 32'(vact[0]), 32'h0);
    chk("coincident_old_vol", 0, 32'(vvol[0]), 32'h0);
    publish();
    chk("next_frame_active", 0, 32'(vact[0]), 32'h1);
    chk("next_frame_freq", 0, 32'(vfreq[0]), 32'h22);
    chk("next_frame_vol", 0, 32'(vvol[0]), 32'h6);

    // Note-on with zero volume releases the voice.
    send(1'b1, 70, 8'h33, 0);
    cyc(NV + 2);
    publish();
    chk("vol0_is_off", 0, 32'(vact[0]), 32'h0);
    chk("vol0_freq_held", 0, 32'(vfreq[0]), 32'h22);

    // Reset in the middle of a scan.
    send(1'b1, 10, 8'h11, 2);
    cyc(NV + 2);
    publish();
    chk("pre_reset_active", 0, 32'(vact[0]), 32'h1);
    send(1'b1, 11, 8'h12, 2);
    cyc(2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midscan_reset_active", 0, 32'(vact[0]), 32'h0);
    chk("midscan_reset_ready", 0, 32'(rdy[0]), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("ready_one_after_release", 0, 32'(rdy[0]), 32'd1);

    // Randomized traffic, frame clock jitter and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      ev_valid = ($urandom_range(0, 1) == 1);
      ev_on    = ($urandom_range(0, 9) < 7);
      ev_note  = NB'($urandom_range(0, 5));
      ev_freq  = FB'($urandom);
      ev_vol   = VB'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) pblrc = ~pblrc;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cyc(2);
        rst_n = 1'b1;
      end
      cyc(1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
